// File: rtl/sdram_line_fetch.sv
// sdram_line_fetch: answers a one-line (128-bit) request from the loader by
// issuing 8 pipelined 16-bit Avalon-MM reads and packing the beats into
// sdram_data. sdram_ac stays high until the loader drops sdram_rd.
// Optional build macro: LINE_FETCH_BYTESWAP_EN swaps the two bytes of every
// captured beat (big-endian asset images); timing is unchanged.
module sdram_line_fetch #(
  parameter int LINE_AW = 22,
  parameter int AVM_AW  = 25,
  parameter int BEATS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_ready,
  input  logic                  sdram_rd,
  input  logic [LINE_AW-1:0]    sdram_addr,
  output logic                  sdram_wait,
  output logic                  sdram_ac,
  output logic [BEATS*16-1:0]   sdram_data,
  output logic [AVM_AW-1:0]     avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [15:0]           avm_readdata,
  input  logic                  avm_readdatavalid
);

  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ACK} state_t;

  state_t                   state, state_n;
  logic [1:0]               rdy_sync;
  logic [CW-1:0]            issue_cnt, beat_cnt;
  logic [BEATS-1:0][15:0]   shadow, line_wr;
  logic [15:0]              beat_data;
  logic                     start, accept, capture, done;

`ifdef LINE_FETCH_BYTESWAP_EN
  assign beat_data = {avm_readdata[7:0], avm_readdata[15:8]};
`else
  assign beat_data = avm_readdata;
`endif

  // Controller-ready is asynchronous; wait follows the second sync flop only.
  always_ff @(posedge clk or posedge reset)
    if (reset) rdy_sync <= '0;
    else       rdy_sync <= {rdy_sync[0], ctrl_ready};

  assign sdram_wait = ~rdy_sync[1];

  // State register.
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;

  // Next state and per-cycle control strobes.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    accept  = 1'b0;
    done    = 1'b0;
    // Beats can come back while reads are still being issued.
    capture = (state == ISSUE || state == DRAIN) && avm_readdatavalid;
    line_wr = shadow;
    line_wr[beat_cnt] = beat_data;
    case (state)
      IDLE:  if (sdram_rd && !sdram_wait) begin
               start   = 1'b1;
               state_n = ISSUE;
             end
      ISSUE: if (!avm_waitrequest) begin
               accept = 1'b1;
               if (issue_cnt == LAST) state_n = DRAIN;
             end
      DRAIN: if (capture && beat_cnt == LAST) begin
               done    = 1'b1;
               state_n = ACK;
             end
      ACK:   if (!sdram_rd) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Read issue, beat capture and line hand-off.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= '0;
      issue_cnt   <= '0;
      beat_cnt    <= '0;
      shadow      <= '0;
      sdram_data  <= '0;
      sdram_ac    <= 1'b0;
    end else begin
      if (start) begin
        // Line base; low bits zero so +7 never carries out of the line.
        avm_address <= {sdram_addr, {CW{1'b0}}};
        avm_read    <= 1'b1;
        issue_cnt   <= '0;
        beat_cnt    <= '0;
      end
      // Address/read only move on an accepted command, so they hold during stalls.
      if (accept) begin
        if (issue_cnt == LAST) begin
          avm_read <= 1'b0;
        end else begin
          issue_cnt   <= issue_cnt + 1'b1;
          avm_address <= avm_address + AVM_AW'(1);
        end
      end
      if (capture) begin
        shadow   <= line_wr;
        beat_cnt <= beat_cnt + 1'b1;
      end
      // Publish the line together with ac; data then holds until the next line.
      if (done) begin
        sdram_data <= line_wr;
        sdram_ac   <= 1'b1;
      end
      if (state == ACK && !sdram_rd) sdram_ac <= 1'b0;
    end

endmodule
